interrupt_dispatch: RTL and testbench
=====================================

// Module: interrupt_dispatch
// PURPOSE
//  Owns the IF/IE registers and IME, and sequences the 5-M-cycle interrupt service
//  (wait, wait, push PCH, push PCL, jump). It is the consuming end of the lowest-set-bit
//  vector encoding: it turns the chosen 3-bit index back into a one-hot IF clear and a
//  jump vector 0x0040 + 8*n. It sits in the CPU control unit beside the instruction
//  sequencer and talks to the memory-mapped register bus.
// PARAMETERS
//  NUM_IRQ      5       interrupt sources; bit 0 is highest priority (VBlank..Joypad)
//  VECTOR_BASE  16'h0040 vector of source 0; each next source adds 8
// PORTS
//  i_Clk          in   1   system clock
//  i_Reset_n      in   1   asynchronous, active-low reset
//  i_M_Cycle_En   in   1   one-clock strobe per M-cycle; all state advances only on it
//  i_Irq_Req      in   5   peripheral request pulses; each sets its IF bit
//  i_Reg_Wr       in   1   bus write strobe
//  i_Reg_Addr     in   16  bus address (IF=FF0F, IE=FFFF)
//  i_Reg_Wdata    in   8   bus write data
//  o_Reg_Rdata    out  8   IF read = {3'b111,IF}; IE read = full 8-bit IE; else 8'h00
//  i_Instr_Bound  in   1   CPU is at an opcode fetch and may be interrupted
//  i_Ei / i_Di / i_Reti in 1 each  decoded EI / DI / RETI executing this M-cycle
//  o_Wake         out  1   |(IE[4:0] & IF), independent of IME (HALT exit)
//  o_Busy         out  1   dispatch in progress; CPU suspends fetch
//  o_Push_Hi      out  1   CPU must SP--, write PC[15:8] this M-cycle
//  o_Push_Lo      out  1   CPU must SP--, write PC[7:0] this M-cycle
//  o_Load_Pc      out  1   CPU must load PC <= o_Vector this M-cycle
//  o_Vector       out  16  jump target; valid while o_Load_Pc
// BEHAVIOUR
//  Reset: IF=5'h00, IE=8'h00, IME=0, EI-pending=0, state IDLE; all outputs 0 except
//   o_Reg_Rdata (combinational on address).
//  Pending = IE[4:0] & IF. Index n = lowest set bit of latched pending; n in 0..4.
//  IF update per i_Clk: IF <= (IF & ~clear) | i_Irq_Req, with bus write replacing the
//   IF term first; a request in the same clock as a write or clear always wins (bit = 1).
//  IME: i_Di clears IME and EI-pending immediately. i_Ei sets EI-pending; IME becomes 1
//   at the next i_Instr_Bound after that (one-instruction delay). i_Reti sets IME at once.
//   EI followed directly by DI leaves IME=0.
//  FSM (transitions only on i_M_Cycle_En):
//   IDLE  -> WAIT1 when i_Instr_Bound & IME & |Pending; IME<=0, o_Busy<=1.
//   WAIT1 -> WAIT2 -> PUSH_HI (o_Push_Hi=1) -> PUSH_LO (o_Push_Lo=1) -> JUMP.
//   PUSH_HI end: Pending re-sampled (after the high-byte write, which may hit IE) and n latched.
//   JUMP: o_Load_Pc=1, o_Vector=VECTOR_BASE+8*n, IF[n] cleared; -> IDLE, o_Busy<=0.
//  Latency: bound sample to o_Load_Pc = exactly 5 M-cycles; strobes are one M-cycle wide
//   and mutually exclusive.
//  Multiple pending: only lowest index serviced; others stay set in IF.
//  IF bits 7:5 ignore writes; IE holds all 8 bits, only [4:0] gate requests.
//  Reset mid-dispatch returns to IDLE immediately; no partial strobe completes.
// CONFIGURATION
//  DISPATCH_CANCEL_QUIRK_EN defined: if Pending re-sampled at PUSH_HI end is zero,
//   JUMP drives o_Vector=16'h0000 and clears no IF bit (hardware cancel behaviour).
//  Undefined: n is latched at IDLE->WAIT1 and never re-sampled; vector always valid.
// TESTING
//  IE=01, IME=1, pulse Irq[0], bound -> 5 M-cycles later o_Load_Pc, Vector=0040, IF=00.
//  IE=1F, IF=0A, IME=1 -> Vector=0048, IF afterwards=08, IME=0, o_Busy low after JUMP.
//  EI then bound then bound with IF&IE=04 -> no dispatch at 1st bound, Vector=0050 at 2nd.
//  IME=0, IE=10, Irq[4] -> o_Wake=1, o_Busy stays 0; EI then DI -> still no dispatch.
//  Same clock: write IF=00 and Irq[2] pulse -> IF reads E4.
//  Quirk on: IE=01,IF=01 dispatch, push-high write IE=00 -> Vector=0000, IF stays 01;
//   quirk off -> Vector=0040.

Source files
------------

// File: rtl/interrupt_dispatch.sv
// Interrupt controller: IF/IE/IME registers and the 5-M-cycle dispatch sequence.
// Optional macro DISPATCH_CANCEL_QUIRK_EN re-samples the pending set after the PCH push.
module interrupt_dispatch #(
    parameter int          NUM_IRQ     = 5,
    parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic               i_M_Cycle_En,
    input  logic [NUM_IRQ-1:0] i_Irq_Req,
    input  logic               i_Reg_Wr,
    input  logic [15:0]        i_Reg_Addr,
    input  logic [7:0]         i_Reg_Wdata,
    output logic [7:0]         o_Reg_Rdata,
    input  logic               i_Instr_Bound,
    input  logic               i_Ei,
    input  logic               i_Di,
    input  logic               i_Reti,
    output logic               o_Wake,
    output logic               o_Busy,
    output logic               o_Push_Hi,
    output logic               o_Push_Lo,
    output logic               o_Load_Pc,
    output logic [15:0]        o_Vector
);

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT1, S_WAIT2, S_PUSH_HI, S_PUSH_LO, S_JUMP
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] if_q, if_d, if_clear, pending;
    logic [7:0]         ie_q, ie_d;
    logic               ime_q, ime_d, ei_pend_q, ei_pend_d;
    logic [2:0]         idx_q, idx_d;
    logic               cancel;

    // Lowest set bit wins: scanning downward leaves the lowest index last.
    function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] p);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (p[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign pending = ie_q[NUM_IRQ-1:0] & if_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        if_clear = '0;
        if (i_M_Cycle_En && state_q == S_JUMP && !cancel) begin
            if_clear = NUM_IRQ'(1) << idx_q;
        end
        if_d = if_q;
        if (i_Reg_Wr && i_Reg_Addr == ADDR_IF) if_d = i_Reg_Wdata[NUM_IRQ-1:0];
        if_d = (if_d & ~if_clear) | i_Irq_Req;
        ie_d = ie_q;
        if (i_Reg_Wr && i_Reg_Addr == ADDR_IE) ie_d = i_Reg_Wdata;
    end

`ifdef DISPATCH_CANCEL_QUIRK_EN
    logic               cancel_q, cancel_d;
    logic [NUM_IRQ-1:0] pending_now;
    assign cancel      = cancel_q;
    // Includes a bus write landing in the same clock as the PUSH_HI boundary.
    assign pending_now = ie_d[NUM_IRQ-1:0] & if_d;
`else
    assign cancel = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
`ifdef DISPATCH_CANCEL_QUIRK_EN
        cancel_d  = cancel_q;
`endif
        if (i_M_Cycle_En) begin
            if (ei_pend_q && i_Instr_Bound) begin
                ime_d     = 1'b1;
                ei_pend_d = 1'b0;
            end
            if (i_Ei)   ei_pend_d = 1'b1;
            if (i_Reti) ime_d     = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (i_Instr_Bound && ime_q && |pending) begin
                        state_d = S_WAIT1;
                        idx_d   = lowest_idx(pending);
                        ime_d   = 1'b0;
                    end
                end
                S_WAIT1:   state_d = S_WAIT2;
                S_WAIT2:   state_d = S_PUSH_HI;
                S_PUSH_HI: begin
                    state_d = S_PUSH_LO;
`ifdef DISPATCH_CANCEL_QUIRK_EN
                    idx_d    = lowest_idx(pending_now);
                    cancel_d = ~|pending_now;
`endif
                end
                S_PUSH_LO: state_d = S_JUMP;
                S_JUMP:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
            if (i_Di) begin
                ime_d     = 1'b0;
                ei_pend_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            if_q      <= '0;
            ie_q      <= '0;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
            idx_q     <= '0;
`ifdef DISPATCH_CANCEL_QUIRK_EN
            cancel_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            if_q      <= if_d;
            ie_q      <= ie_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
            idx_q     <= idx_d;
`ifdef DISPATCH_CANCEL_QUIRK_EN
            cancel_q  <= cancel_d;
`endif
        end
    end

    always_comb begin
        o_Busy    = (state_q != S_IDLE);
        o_Push_Hi = (state_q == S_PUSH_HI);
        o_Push_Lo = (state_q == S_PUSH_LO);
        o_Load_Pc = (state_q == S_JUMP);
        o_Vector  = '0;
        if (o_Load_Pc && !cancel) o_Vector = VECTOR_BASE + {10'd0, idx_q, 3'b000};
        o_Wake    = |pending;
        o_Reg_Rdata = 8'h00;
        if (i_Reg_Addr == ADDR_IF)      o_Reg_Rdata = {{(8 - NUM_IRQ){1'b1}}, if_q};
        else if (i_Reg_Addr == ADDR_IE) o_Reg_Rdata = ie_q;
    end

endmodule

// File: tb/tb_interrupt_dispatch.sv
// Directed bench for interrupt_dispatch; expected jump vectors go through a scoreboard queue.
module tb_interrupt_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_en = 1'b0;
    logic [4:0]  irq = '0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        bound = 1'b0, ei = 1'b0, di = 1'b0, reti = 1'b0;
    logic        wake, busy, push_hi, push_lo, load_pc;
    logic [15:0] vector;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    interrupt_dispatch dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_M_Cycle_En(m_en), .i_Irq_Req(irq),
        .i_Reg_Wr(wr), .i_Reg_Addr(addr), .i_Reg_Wdata(wdata), .o_Reg_Rdata(rdata),
        .i_Instr_Bound(bound), .i_Ei(ei), .i_Di(di), .i_Reti(reti),
        .o_Wake(wake), .o_Busy(busy), .o_Push_Hi(push_hi), .o_Push_Lo(push_lo),
        .o_Load_Pc(load_pc), .o_Vector(vector)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One M-cycle is four clocks with the enable in the last one.
    task automatic step_m();
        repeat (3) @(negedge clk);
        m_en = 1'b1;
        @(negedge clk);
        m_en = 1'b0;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        @(negedge clk);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic pulse_irq(input logic [4:0] m);
        @(negedge clk);
        irq = m;
        @(negedge clk);
        irq = '0;
    endtask

    task automatic reti_step();
        reti = 1'b1; step_m(); reti = 1'b0;
    endtask

    task automatic bound_step_idle(input string tag);
        bound = 1'b1; step_m(); bound = 1'b0;
        check(tag, busy, 1'b0);
    endtask

    task automatic run_dispatch(input string tag, input logic [15:0] exp_vec, input bit ie_hit);
        int n;
        logic [15:0] exp;
        exp_q.push_back(exp_vec);
        bound = 1'b1; step_m(); bound = 1'b0;
        n = 1;
        check({tag, "_busy_start"}, busy, 1'b1);
        while (!load_pc && n < 12) begin
            if (push_hi && ie_hit) reg_write(16'hFFFF, 8'h00);
            step_m();
            n++;
            check({tag, "_strobe_excl"}, $onehot0({push_hi, push_lo, load_pc}), 1'b1);
            if (n == 3) check({tag, "_push_hi"}, push_hi, 1'b1);
            if (n == 4) check({tag, "_push_lo"}, push_lo, 1'b1);
        end
        check({tag, "_latency"}, n, 5);
        exp = exp_q.pop_front();
        check({tag, "_vector"}, vector, exp);
        step_m();
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_load_end"}, load_pc, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        addr = 16'h1234;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {push_hi, push_lo, load_pc}, 3'b000);
        check("rst_vector", vector, 16'h0000);
        check("rst_wake", wake, 1'b0);
        check("rst_other_addr", rdata, 8'h00);
        rst_n = 1'b1;
        read_check("rst_if", 16'hFF0F, 8'hE0);
        read_check("rst_ie", 16'hFFFF, 8'h00);

        // Single source 0 through the full sequence
        reg_write(16'hFFFF, 8'h01);
        reti_step();
        pulse_irq(5'h01);
        read_check("t1_if_set", 16'hFF0F, 8'hE1);
        check("t1_wake", wake, 1'b1);
        run_dispatch("t1", 16'h0040, 1'b0);
        read_check("t1_if_after", 16'hFF0F, 8'hE0);

        // Priority: IF=0A picks source 1, leaves bit 3, IME cleared
        reg_write(16'hFFFF, 8'h1F);
        reg_write(16'hFF0F, 8'h0A);
        reti_step();
        run_dispatch("t2", 16'h0048, 1'b0);
        read_check("t2_if_after", 16'hFF0F, 8'hE8);
        bound_step_idle("t2_ime_cleared");

        // EI delay: first bound only arms IME
        reg_write(16'hFF0F, 8'h04);
        ei = 1'b1; step_m(); ei = 1'b0;
        bound_step_idle("t3_no_dispatch_first_bound");
        run_dispatch("t3", 16'h0050, 1'b0);
        read_check("t3_if_after", 16'hFF0F, 8'hE0);

        // IME=0: wake without dispatch; EI then DI keeps IME off
        reg_write(16'hFFFF, 8'h10);
        pulse_irq(5'h10);
        read_check("t4_if", 16'hFF0F, 8'hF0);
        check("t4_wake", wake, 1'b1);
        bound_step_idle("t4_no_dispatch");
        ei = 1'b1; step_m(); ei = 1'b0;
        di = 1'b1; step_m(); di = 1'b0;
        bound_step_idle("t4_ei_di_bound1");
        bound_step_idle("t4_ei_di_bound2");

        // Request in the same clock as an IF write wins
        @(negedge clk);
        wr = 1'b1; addr = 16'hFF0F; wdata = 8'h00; irq = 5'h04;
        @(negedge clk);
        wr = 1'b0; irq = '0;
        read_check("t5_write_vs_req", 16'hFF0F, 8'hE4);

        // IE keeps all 8 bits; only [4:0] gate wake
        reg_write(16'hFFFF, 8'hA0);
        read_check("t6_ie_full", 16'hFFFF, 8'hA0);
        check("t6_wake_masked", wake, 1'b0);
        reg_write(16'hFF0F, 8'hFF);
        read_check("t6_if_upper_ro", 16'hFF0F, 8'hFF);

        // Two pending: lowest serviced, the other remains
        reg_write(16'hFFFF, 8'h1F);
        reg_write(16'hFF0F, 8'h14);
        reti_step();
        run_dispatch("t7", 16'h0050, 1'b0);
        read_check("t7_if_after", 16'hFF0F, 8'hF0);

        // Reset during PUSH_HI
        reg_write(16'hFF0F, 8'h01);
        reti_step();
        bound = 1'b1; step_m(); bound = 1'b0;
        step_m();
        step_m();
        check("t8_in_push_hi", push_hi, 1'b1);
        addr = 16'hFF0F;
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_busy", busy, 1'b0);
        check("t8_rst_push", push_hi, 1'b0);
        check("t8_rst_if", rdata, 8'hE0);
        @(negedge clk);
        rst_n = 1'b1;
        step_m();
        check("t8_after_busy", busy, 1'b0);

        // IE cleared by the PCH push
        reg_write(16'hFFFF, 8'h01);
        reg_write(16'hFF0F, 8'h01);
        reti_step();
`ifdef DISPATCH_CANCEL_QUIRK_EN
        run_dispatch("t9", 16'h0000, 1'b1);
        read_check("t9_if_after", 16'hFF0F, 8'hE1);
`else
        run_dispatch("t9", 16'h0040, 1'b1);
        read_check("t9_if_after", 16'hFF0F, 8'hE0);
`endif
        read_check("t9_ie_after", 16'hFFFF, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
